// File: rtl/nibble_serial_adder_ctrl_if.sv
// Purpose : bundles the operand/result valid-ready channels and the external 4-bit adder hookup.
// Latency : n/a (signal bundle only).
// Backpr. : n/a; the slave modport is the sequencer side, the master modport is the surrounding logic.
//
// Signals: in_valid/in_ready/A/B/Cin (operation in), out_valid/out_ready/Sum/Cout (result out),
//          add_X/add_Y/add_Cin (to adder), add_S/add_Cout (from adder).
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic [3:0]   add_X;
    logic [3:0]   add_Y;
    logic         add_Cin;
    logic [3:0]   add_S;
    logic         add_Cout;

    modport master (
        output in_valid, A, B, Cin, out_ready, add_S, add_Cout,
        input  in_ready, out_valid, Sum, Cout, add_X, add_Y, add_Cin
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready, add_S, add_Cout,
        output in_ready, out_valid, Sum, Cout, add_X, add_Y, add_Cin
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose : wide add (4*NIBBLES bits) sequenced LSB-first through one external 4-bit adder.
// Latency : NIBBLES cycles from the input handshake edge to out_valid; one op per NIBBLES+2 cycles max.
// Backpr. : result held stable in DONE until out_ready; in_ready stays low until the result is taken.
//
// Ports: clk, rst_n (async active-low), bus (slave modport of nibble_serial_adder_ctrl_if).
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry;
    logic [IW-1:0] idx;
    logic          in_ready_q;
    logic          out_valid_q;

    // Bit offset of the nibble currently being added.
    logic [IW+1:0] base;
    assign base = {idx, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone is the handshake.
                    if (bus.in_valid) begin
                        a_reg      <= bus.A;
                        b_reg      <= bus.B;
                        carry      <= bus.Cin;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[base +: 4] <= bus.add_S;
                    carry              <= bus.add_Cout;
                    if (idx == IW'(NIBBLES - 1)) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Adder operands come only from registers, so they are quiet (zero) outside RUN.
    logic [3:0] add_x_c;
    logic [3:0] add_y_c;
    logic       add_cin_c;

    always_comb begin
        add_x_c   = 4'd0;
        add_y_c   = 4'd0;
        add_cin_c = 1'b0;
        if (state == RUN) begin
            add_x_c   = a_reg[base +: 4];
            add_y_c   = b_reg[base +: 4];
            add_cin_c = carry;
        end
    end

    assign bus.add_X     = add_x_c;
    assign bus.add_Y     = add_y_c;
    assign bus.add_Cin   = add_cin_c;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_reg;
    assign bus.Cout      = carry;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Purpose : scoreboard bench for nibble_serial_adder_ctrl at NIBBLES=4 (directed + random) and NIBBLES=2 (random).
// Latency : expected results are queued at the accept edge and popped at each result handshake.
// Backpr. : out_ready is driven directly or randomised; the bench stalls results to exercise hold behaviour.
module tb_nibble_serial_adder_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.NIBBLES(4)) ifc ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(2)) ifc2 ();

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
    nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2.slave));

    // Behavioural 4-bit ripple adder stage that each sequencer drives.
    assign {ifc.add_Cout, ifc.add_S}   = {1'b0, ifc.add_X} + {1'b0, ifc.add_Y} + {4'b0, ifc.add_Cin};
    assign {ifc2.add_Cout, ifc2.add_S} = {1'b0, ifc2.add_X} + {1'b0, ifc2.add_Y} + {4'b0, ifc2.add_Cin};

    int n_chk = 0;
    int n_err = 0;
    int acc4 = 0, res4 = 0, acc2 = 0, res2 = 0;
    logic [16:0] q4[$];
    logic [8:0]  q2[$];
    logic [16:0] e4;
    logic [8:0]  e2;
    bit   rand4   = 1'b0;
    logic dir_rdy = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // out_ready changes just after the rising edge so it is stable at every sampling point.
    always @(posedge clk) begin
        #1;
        ifc.out_ready  = rand4 ? 1'($urandom_range(0, 1)) : dir_rdy;
        ifc2.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitors: a result transfers on the next rising edge whenever valid and ready are seen here.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
            res4++;
            if (q4.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL dut4 unexpected result: got %h expected none", {ifc.Cout, ifc.Sum});
            end else begin
                e4 = q4.pop_front();
                chk("dut4 result", 32'({ifc.Cout, ifc.Sum}), 32'(e4));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc2.out_valid === 1'b1 && ifc2.out_ready === 1'b1) begin
            res2++;
            if (q2.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL dut2 unexpected result: got %h expected none", {ifc2.Cout, ifc2.Sum});
            end else begin
                e2 = q2.pop_front();
                chk("dut2 result", 32'({ifc2.Cout, ifc2.Sum}), 32'(e2));
            end
        end
    end

    task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic c);
        int t = 0;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b1;
        ifc.A = a;
        ifc.B = b;
        ifc.Cin = c;
        do begin
            @(negedge clk);
            t++;
        end while (ifc.in_ready !== 1'b1 && t < 200);
        if (ifc.in_ready !== 1'b1) begin
            chk("dut4 accept timeout in_ready", 32'(ifc.in_ready), 32'd1);
            ifc.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        q4.push_back({1'b0, a} + {1'b0, b} + 17'(c));
        acc4++;
        #1 ifc.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic c);
        int t = 0;
        @(posedge clk);
        #1;
        ifc2.in_valid = 1'b1;
        ifc2.A = a;
        ifc2.B = b;
        ifc2.Cin = c;
        do begin
            @(negedge clk);
            t++;
        end while (ifc2.in_ready !== 1'b1 && t < 200);
        if (ifc2.in_ready !== 1'b1) begin
            chk("dut2 accept timeout in_ready", 32'(ifc2.in_ready), 32'd1);
            ifc2.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        q2.push_back({1'b0, a} + {1'b0, b} + 9'(c));
        acc2++;
        #1 ifc2.in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " in_ready"},  32'(ifc.in_ready),  32'd1);
        chk({tag, " out_valid"}, 32'(ifc.out_valid), 32'd0);
        chk({tag, " Sum"},       32'(ifc.Sum),       32'd0);
        chk({tag, " Cout"},      32'(ifc.Cout),      32'd0);
        chk({tag, " add_X"},     32'(ifc.add_X),     32'd0);
        chk({tag, " add_Y"},     32'(ifc.add_Y),     32'd0);
        chk({tag, " add_Cin"},   32'(ifc.add_Cin),   32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while ((q4.size() != 0 || q2.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Hand-computed nibble streams (LSB first).
    logic [3:0] x1[4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] y1[4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    logic       c2[4] = '{1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset with garbage on the inputs.
        ifc.in_valid  = 1'($urandom_range(0, 1));
        ifc.A         = 16'($urandom);
        ifc.B         = 16'($urandom);
        ifc.Cin       = 1'($urandom_range(0, 1));
        ifc2.in_valid = 1'b0;
        ifc2.A        = 8'h00;
        ifc2.B        = 8'h00;
        ifc2.Cin      = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post-reset out_valid", 32'(ifc.out_valid), 32'd0);
        end

        // 0x1234 + 0x4321: nibble stream and 4-cycle latency.
        send4(16'h1234, 16'h4321, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("run1 add_X",     32'(ifc.add_X),     32'(x1[k]));
            chk("run1 add_Y",     32'(ifc.add_Y),     32'(y1[k]));
            chk("run1 add_Cin",   32'(ifc.add_Cin),   32'd0);
            chk("run1 out_valid", 32'(ifc.out_valid), 32'd0);
            chk("run1 in_ready",  32'(ifc.in_ready),  32'd0);
        end
        @(negedge clk);
        chk("run1 latency out_valid", 32'(ifc.out_valid), 32'd1);

        // 0xFFFF + 0 + 1: carry ripples through every nibble.
        send4(16'hFFFF, 16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("run2 add_Cin", 32'(ifc.add_Cin), 32'(c2[k]));
            chk("run2 add_X",   32'(ifc.add_X),   32'hF);
        end
        @(negedge clk);
        chk("run2 latency out_valid", 32'(ifc.out_valid), 32'd1);
        repeat (2) @(negedge clk);

        // Backpressure: result held while a new request waits.
        dir_rdy = 1'b0;
        send4(16'h8000, 16'h8000, 1'b0);
        ifc.in_valid = 1'b1;
        ifc.A = 16'h1111;
        ifc.B = 16'h2222;
        ifc.Cin = 1'b0;
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (ifc.out_valid !== 1'b1 && t < 50);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall out_valid", 32'(ifc.out_valid), 32'd1);
            chk("stall Sum",       32'(ifc.Sum),       32'h0000);
            chk("stall Cout",      32'(ifc.Cout),      32'd1);
            chk("stall in_ready",  32'(ifc.in_ready),  32'd0);
        end
        dir_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release in_ready",  32'(ifc.in_ready),  32'd1);
        chk("release out_valid", 32'(ifc.out_valid), 32'd0);
        @(posedge clk);
        q4.push_back(17'h03333);
        acc4++;
        #1 ifc.in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Reset two cycles into RUN discards the operation.
        send4(16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        acc4 -= q4.size();
        q4.delete();
        #1;
        check_idle_outputs("async reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("after abort out_valid", 32'(ifc.out_valid), 32'd0);
        end
        send4(16'h0001, 16'h0001, 1'b1);
        drain();

        // Random regression on both widths in parallel.
        rand4 = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send4(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                end
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send2(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                end
            end
        join
        rand4 = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        chk("dut4 result count", 32'(res4), 32'(acc4));
        chk("dut2 result count", 32'(res2), 32'(acc2));
        chk("dut4 queue empty",  32'(q4.size()), 32'd0);
        chk("dut2 queue empty",  32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
